// File: rtl/punc_control.sv
// Instruction-sequencing FSM for the PUnC LC3 datapath: fetch, decode, execute.
// Optional build macro PUNC_ILLEGAL_TRAP_EN: opcodes 1000/1101 halt and set a sticky illegal flag.
module punc_control (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] ir,
  input  logic        n,
  input  logic        z,
  input  logic        p,
  output logic        pc_ld,
  output logic        pc_inc,
  output logic        pc_clr,
  output logic        pc_data_sel,
  output logic        pc_off_sel,
  output logic        ir_ld,
  output logic [1:0]  mem_addr_sel,
  output logic        mem_w_en,
  output logic        store_ld,
  output logic [2:0]  rf_r_addr_0,
  output logic [2:0]  rf_r_addr_1,
  output logic [2:0]  rf_w_addr,
  output logic [1:0]  rf_w_sel,
  output logic        rf_w_en,
  output logic        alu_a_sel,
  output logic        alu_b_sel,
  output logic [1:0]  alu_op,
  output logic        nzp_ld,
  output logic        nzp_sel,
  output logic        halted,
  output logic        illegal
);

  // state    | meaning
  // S_FETCH  | read mem[PC] into IR, PC <= PC+1
  // S_DECODE | IR stable, register file read addresses settle
  // S_EXEC   | perform the instruction (or branch to EXEC2/HALT)
  // S_EXEC2  | second memory access of LDI/STI via the indirect register
  // S_HALT   | TRAP or illegal opcode; only rst leaves

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_EXEC2  = 3'd3,
    S_HALT   = 3'd4
  } state_t;

  localparam logic [3:0] OP_BR   = 4'b0000;
  localparam logic [3:0] OP_ADD  = 4'b0001;
  localparam logic [3:0] OP_LD   = 4'b0010;
  localparam logic [3:0] OP_ST   = 4'b0011;
  localparam logic [3:0] OP_JSR  = 4'b0100;
  localparam logic [3:0] OP_AND  = 4'b0101;
  localparam logic [3:0] OP_LDR  = 4'b0110;
  localparam logic [3:0] OP_STR  = 4'b0111;
  localparam logic [3:0] OP_RSV0 = 4'b1000;
  localparam logic [3:0] OP_NOT  = 4'b1001;
  localparam logic [3:0] OP_LDI  = 4'b1010;
  localparam logic [3:0] OP_STI  = 4'b1011;
  localparam logic [3:0] OP_JMP  = 4'b1100;
  localparam logic [3:0] OP_RSV1 = 4'b1101;
  localparam logic [3:0] OP_LEA  = 4'b1110;
  localparam logic [3:0] OP_TRAP = 4'b1111;

  state_t     state_q, state_d;
  logic [3:0] opcode;
  logic       br_taken;
  logic       is_store;
  logic       unused_ir_bits;

  assign opcode         = ir[15:12];
  assign br_taken       = (ir[11] & n) | (ir[10] & z) | (ir[9] & p);
  assign is_store       = (opcode == OP_ST) || (opcode == OP_STR) || (opcode == OP_STI);
  // ir[4:3] only matter to the datapath's immediate decode
  assign unused_ir_bits = ^ir[4:3];

`ifdef PUNC_ILLEGAL_TRAP_EN
  logic illegal_set;
  logic illegal_q;

  always_ff @(posedge clk) begin
    if (rst)
      illegal_q <= 1'b0;
    else if (illegal_set)
      illegal_q <= 1'b1;
  end

  assign illegal = illegal_q;
`else
  assign illegal = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst)
      state_q <= S_FETCH;
    else
      state_q <= state_d;
  end

  always_comb begin
    state_d      = state_q;
    pc_ld        = 1'b0;
    pc_inc       = 1'b0;
    pc_clr       = 1'b0;
    pc_data_sel  = 1'b0;
    pc_off_sel   = 1'b0;
    ir_ld        = 1'b0;
    mem_addr_sel = 2'd0;
    mem_w_en     = 1'b0;
    store_ld     = 1'b0;
    rf_r_addr_0  = ir[8:6];
    rf_r_addr_1  = is_store ? ir[11:9] : ir[2:0];
    rf_w_addr    = ir[11:9];
    rf_w_sel     = 2'd0;
    rf_w_en      = 1'b0;
    alu_a_sel    = 1'b0;
    alu_b_sel    = 1'b0;
    alu_op       = 2'd0;
    nzp_ld       = 1'b0;
    nzp_sel      = 1'b0;
    halted       = 1'b0;
`ifdef PUNC_ILLEGAL_TRAP_EN
    illegal_set  = 1'b0;
`endif

    // Reset masks every strobe so an interrupted EXEC2 never writes.
    if (rst) begin
      pc_clr = 1'b1;
    end else begin
      case (state_q)
        S_FETCH: begin
          ir_ld   = 1'b1;
          pc_inc  = 1'b1;
          state_d = S_DECODE;
        end
        S_DECODE: state_d = S_EXEC;
        S_EXEC: begin
          state_d = S_FETCH;
          case (opcode)
            OP_ADD, OP_AND, OP_NOT: begin
              alu_a_sel = 1'b1;
              alu_b_sel = (opcode == OP_NOT) ? 1'b0 : ir[5];
              alu_op    = (opcode == OP_AND) ? 2'd1 : (opcode == OP_NOT) ? 2'd2 : 2'd0;
              rf_w_sel  = 2'd2;
              rf_w_en   = 1'b1;
              nzp_ld    = 1'b1;
            end
            OP_BR: begin
              pc_off_sel = 1'b1;
              pc_ld      = br_taken;
            end
            OP_JMP: begin
              pc_data_sel = 1'b1;
              pc_ld       = 1'b1;
            end
            OP_JSR: begin
              rf_w_addr   = 3'd7;
              rf_w_sel    = 2'd0;
              rf_w_en     = 1'b1;
              pc_data_sel = ~ir[11];
              pc_ld       = 1'b1;
            end
            OP_LD, OP_LDR: begin
              mem_addr_sel = 2'd1;
              alu_a_sel    = (opcode == OP_LDR);
              alu_b_sel    = 1'b1;
              rf_w_sel     = 2'd1;
              rf_w_en      = 1'b1;
              nzp_ld       = 1'b1;
              nzp_sel      = 1'b1;
            end
            OP_LEA: begin
              alu_b_sel = 1'b1;
              rf_w_sel  = 2'd2;
              rf_w_en   = 1'b1;
              nzp_ld    = 1'b1;
            end
            OP_ST, OP_STR: begin
              mem_addr_sel = 2'd1;
              alu_a_sel    = (opcode == OP_STR);
              alu_b_sel    = 1'b1;
              mem_w_en     = 1'b1;
            end
            OP_LDI, OP_STI: begin
              mem_addr_sel = 2'd1;
              alu_b_sel    = 1'b1;
              store_ld     = 1'b1;
              state_d      = S_EXEC2;
            end
            OP_TRAP: state_d = S_HALT;
            OP_RSV0, OP_RSV1: begin
`ifdef PUNC_ILLEGAL_TRAP_EN
              illegal_set = 1'b1;
              state_d     = S_HALT;
`else
              state_d     = S_FETCH;
`endif
            end
            default: state_d = S_FETCH;
          endcase
        end
        S_EXEC2: begin
          mem_addr_sel = 2'd2;
          state_d      = S_FETCH;
          if (opcode == OP_STI) begin
            mem_w_en = 1'b1;
          end else begin
            rf_w_sel = 2'd1;
            rf_w_en  = 1'b1;
            nzp_ld   = 1'b1;
            nzp_sel  = 1'b1;
          end
        end
        S_HALT: halted = 1'b1;
        default: state_d = S_FETCH;
      endcase
    end
  end

endmodule
